// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MIPS core (priority) and a DMA requester.
// Optional perf counters perf_stall/perf_dbeats are enabled with `define DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int BURST_MAX    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_last,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_stall,
  output logic [31:0]   perf_dbeats
`endif
);

  typedef enum logic {S_CORE = 1'b0, S_DMA = 1'b1} state_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
  localparam logic [3:0] BEAT_END   = 4'(BURST_MAX - 1);
  localparam bit         BURST_LOCK = (BURST_MAX > 1);

  state_t        state_reg, state_next;
  logic [7:0]    starve_cnt_reg, starve_cnt_next;
  logic [3:0]    beat_cnt_reg, beat_cnt_next;
  logic          d_rvalid_reg;
  logic [DW-1:0] d_rdata_reg;
  logic          grant_d, grant_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_CORE;
      starve_cnt_reg <= '0;
      beat_cnt_reg   <= '0;
      d_rvalid_reg   <= 1'b0;
      d_rdata_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      beat_cnt_reg   <= beat_cnt_next;
      d_rvalid_reg   <= grant_d & ~d_we;
      if (grant_d && !d_we)
        d_rdata_reg <= m_rdata;
    end
  end

  always_comb begin
    grant_d         = d_req & ((state_reg == S_DMA) | ~c_req | (starve_cnt_reg == STARVE_MAX));
    grant_c         = c_req & ~grant_d;
    state_next      = state_reg;
    beat_cnt_next   = beat_cnt_reg;
    starve_cnt_next = starve_cnt_reg;

    if (grant_d)
      starve_cnt_next = '0;
    else if (d_req && starve_cnt_reg != STARVE_MAX)
      starve_cnt_next = starve_cnt_reg + 8'd1;

    // Inside S_DMA grant_d equals d_req, so d_req low means the burst was abandoned.
    case (state_reg)
      S_CORE: begin
        if (grant_d && !d_last && BURST_LOCK) begin
          state_next    = S_DMA;
          beat_cnt_next = 4'd1;
        end
      end
      S_DMA: begin
        if (!d_req || d_last || beat_cnt_reg == BEAT_END) begin
          state_next    = S_CORE;
          beat_cnt_next = '0;
        end else begin
          beat_cnt_next = beat_cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next    = S_CORE;
        beat_cnt_next = '0;
      end
    endcase

    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (grant_c) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (grant_d) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  assign d_gnt    = grant_d;
  assign c_stall  = c_req & grant_d;
  assign c_rdata  = m_rdata;
  assign d_rvalid = d_rvalid_reg;
  assign d_rdata  = d_rdata_reg;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_reg, perf_dbeats_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_reg  <= '0;
      perf_dbeats_reg <= '0;
    end else begin
      if (c_stall && perf_stall_reg != 32'hFFFF_FFFF)
        perf_stall_reg <= perf_stall_reg + 32'd1;
      if (grant_d && perf_dbeats_reg != 32'hFFFF_FFFF)
        perf_dbeats_reg <= perf_dbeats_reg + 32'd1;
    end
  end

  assign perf_stall  = perf_stall_reg;
  assign perf_dbeats = perf_dbeats_reg;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the single-cycle MIPS core and a DMA/loader requester.
- Sits between `mips`, the DMA port and `datamem` inside `top`.
- The core has priority, and a stall output freezes its PC while the DMA is granted.
- A starvation limit guarantees DMA progress; a burst lock keeps multi-beat DMA transfers contiguous.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIMIT, 8, consecutive DMA wait cycles before a grant is forced (range 1..255).
- BURST_MAX, 4, maximum DMA beats held under one lock (range 1..16).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- c_req  in  1  core data access this cycle (load or store).
- c_we  in  1  core store.
- c_addr  in  AW  core byte address.
- c_wdata  in  DW  core store data.
- c_rdata  out  DW  core load data.
- c_stall  out  1  core must hold its state this cycle.
- d_req  in  1  DMA beat request; held until d_gnt.
- d_we  in  1  DMA write.
- d_last  in  1  final beat of the DMA burst.
- d_addr  in  AW  DMA address.
- d_wdata  in  DW  DMA write data.
- d_gnt  out  1  DMA beat accepted this cycle.
- d_rvalid  out  1  d_rdata valid (one cycle after a read grant).
- d_rdata  out  DW  registered DMA read data.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data; combinational read, synchronous write.

Behaviour:
- State register: S_CORE (reset state) and S_DMA (burst locked).
- Counters:
  - starve_cnt: 8-bit, saturating at STARVE_LIMIT.
  - beat_cnt: 4-bit.
- Grant logic is combinational from the current state and inputs:
  - grant_d = d_req & (state==S_DMA | !c_req | starve_cnt==STARVE_LIMIT).
  - grant_c = c_req & !grant_d.
  - d_gnt = grant_d.
  - c_stall = c_req & grant_d.
- Memory mux:
  - When grant_c: m_we=c_we, m_addr=c_addr, m_wdata=c_wdata.
  - When grant_d: the d_* fields drive the memory port.
  - Otherwise: m_we=0, m_addr=0, m_wdata=0.
- c_rdata = m_rdata combinationally. Its value is only meaningful when grant_c & !c_we.
- DMA read path:
  - grant_d & !d_we: d_rdata <= m_rdata and d_rvalid <= 1 on the next edge.
  - Any other cycle: d_rvalid <= 0 and d_rdata holds its value.
- starve_cnt:
  - Clears on grant_d.
  - Increments when d_req & !grant_d, saturating at STARVE_LIMIT.
  - Holds its value when d_req is low.
- S_CORE to S_DMA when grant_d & !d_last & BURST_MAX>1; beat_cnt <= 1.
- In S_DMA, each grant_d increments beat_cnt.
- S_DMA to S_CORE when any of the following holds:
  - grant_d & d_last.
  - grant_d & beat_cnt==BURST_MAX-1.
  - !d_req (burst abandoned). The core is granted in that same cycle if it requests.
- Leaving S_DMA clears beat_cnt.
- A burst that reaches BURST_MAX without d_last releases the lock. The DMA then re-arbitrates as a new request.
- Simultaneous c_req & d_req in S_CORE with starve_cnt<STARVE_LIMIT: the core wins and starve_cnt increments.
- In S_DMA, the core stalls for every remaining beat of the burst.
- No requests: all memory outputs 0 and state unchanged.
- Reset asserted (including mid-burst):
  - state=S_CORE, starve_cnt=0, beat_cnt=0.
  - d_rvalid=0, d_rdata=0.
  - All combinational outputs then follow the equations above.
  - An interrupted burst is dropped, and the DMA must re-request.
- Latency:
  - Core access is zero-cycle when granted.
  - DMA write completes at the edge ending its grant cycle.
  - DMA read data arrives one cycle after its grant.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined, two extra outputs are added, each cleared by reset and saturating at 32'hFFFFFFFF:
  - perf_stall  out 32, counts cycles with c_stall=1.
  - perf_dbeats  out 32, counts cycles with grant_d=1.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Core only: c_req=1, c_we=1, c_addr=84, c_wdata=5 -> m_we=1, m_addr=84, m_wdata=5, c_stall=0, d_gnt=0; a following load from 84 returns c_rdata=5.
- DMA only: d_req=1, d_we=0, d_addr=0x40 with mem[0x40]=0xDEADBEEF, d_last=1 -> d_gnt=1 in that cycle; next cycle d_rvalid=1, d_rdata=0xDEADBEEF; state stays S_CORE.
- Starvation: c_req and d_req held high from reset with STARVE_LIMIT=8 -> core granted for 8 cycles, DMA granted on cycle 9 with c_stall=1 in that cycle, then starve_cnt=0.
- Burst lock: 4-beat DMA write burst (d_last on beat 4) to addrs 0x100..0x10C while c_req=1 -> first beat granted when the core is idle; then c_stall=1 for beats 2-4; core granted the cycle after beat 4.
- Burst cap: BURST_MAX=4, 6-beat burst with the core requesting -> lock released after beat 4; the core is granted, and the DMA regains the grant once starve_cnt reaches STARVE_LIMIT.
- Reset mid-burst: reset=0 during beat 2 of a 4-beat read burst -> d_rvalid=0, d_rdata=0, state S_CORE; after release, a core request is granted immediately with c_stall=0.
